// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-ported register file: read ports, write ports,
// load scoreboard and clear-sweep control.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_a;
  logic              busy_b;
  logic              wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              sb_set_en;
  logic [ADDR_W-1:0] sb_set_addr;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output rd_addr_a, rd_addr_b,
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output sb_set_en, sb_set_addr, clr_req,
    input  rd_data_a, rd_data_b, busy_a, busy_b, clr_busy
  );

  modport slave (
    input  rd_addr_a, rd_addr_b,
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  sb_set_en, sb_set_addr, clr_req,
    output rd_data_a, rd_data_b, busy_a, busy_b, clr_busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Two-read / two-write register file with optional zero register, write
// bypass, per-register load-pending bits and a one-register-per-cycle clear sweep.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  // Writable/readable location: inside the implemented depth and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              idle;
  logic              wr0_ok, wr1_ok, sb_ok;
  logic [DATA_W-1:0] stored_a, stored_b;
  logic              pend_a, pend_b;

  assign idle   = (state == IDLE);
  assign wr0_ok = bus.wr0_en    && addr_ok(bus.wr0_addr);
  assign wr1_ok = bus.wr1_en    && addr_ok(bus.wr1_addr);
  assign sb_ok  = bus.sb_set_en && addr_ok(bus.sb_set_addr);
  assign bus.clr_busy = (state == SWEEP);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
        end
      end
      SWEEP: begin
        idx_nxt = idx + 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Storage update: the sweep owns the array exclusively; otherwise load return beats ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!idle) begin
          if (idx == ADDR_W'(i)) regs[i] <= '0;
        end else if (wr1_ok && (bus.wr1_addr == ADDR_W'(i))) begin
          regs[i] <= bus.wr1_data;
        end else if (wr0_ok && (bus.wr0_addr == ADDR_W'(i))) begin
          regs[i] <= bus.wr0_data;
        end
      end
    end
  end

  // Pending bits: set beats load-return clear; a sweep start wipes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (idle) begin
      if (bus.clr_req) begin
        pending <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (sb_ok && (bus.sb_set_addr == ADDR_W'(i))) pending[i] <= 1'b1;
          else if (wr1_ok && (bus.wr1_addr == ADDR_W'(i))) pending[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    pend_a   = 1'b0;
    pend_b   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.rd_addr_a == ADDR_W'(i)) begin
        stored_a = regs[i];
        pend_a   = pending[i];
      end
      if (bus.rd_addr_b == ADDR_W'(i)) begin
        stored_b = regs[i];
        pend_b   = pending[i];
      end
    end
  end

  // Read ports: bypass and busy only apply outside the sweep.
  always_comb begin
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    bus.busy_a    = 1'b0;
    bus.busy_b    = 1'b0;
    if (!rst && addr_ok(bus.rd_addr_a)) begin
      bus.rd_data_a = stored_a;
      if (idle) begin
        if ((BYPASS != 0) && bus.wr1_en && (bus.wr1_addr == bus.rd_addr_a))
          bus.rd_data_a = bus.wr1_data;
        else if ((BYPASS != 0) && bus.wr0_en && (bus.wr0_addr == bus.rd_addr_a))
          bus.rd_data_a = bus.wr0_data;
        bus.busy_a = pend_a && !(bus.wr1_en && (bus.wr1_addr == bus.rd_addr_a));
      end
    end
    if (!rst && addr_ok(bus.rd_addr_b)) begin
      bus.rd_data_b = stored_b;
      if (idle) begin
        if ((BYPASS != 0) && bus.wr1_en && (bus.wr1_addr == bus.rd_addr_b))
          bus.rd_data_b = bus.wr1_data;
        else if ((BYPASS != 0) && bus.wr0_en && (bus.wr0_addr == bus.rd_addr_b))
          bus.rd_data_b = bus.wr0_data;
        bus.busy_b = pend_b && !(bus.wr1_en && (bus.wr1_addr == bus.rd_addr_b));
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the presented DUT outputs.
module tb_reg_file_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum int {S_RDA, S_RDB, S_BSA, S_BSB, S_CLR} sig_t;
  typedef struct {
    string       name;
    sig_t        sig;
    logic [31:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  chk_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] fill(input int i);
    fill = 32'hA500_0000 | 32'(i);
  endfunction

  task automatic expect_val(input string name, input sig_t s, input logic [31:0] e);
    chk_t c;
    c.name = name;
    c.sig  = s;
    c.exp  = e;
    sb_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.wr0_en      = 1'b0;
    bus.wr0_addr    = '0;
    bus.wr0_data    = '0;
    bus.wr1_en      = 1'b0;
    bus.wr1_addr    = '0;
    bus.wr1_data    = '0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = '0;
    bus.clr_req     = 1'b0;
  endtask

  task automatic set_rd(input int a, input int b);
    bus.rd_addr_a = ADDR_W'(a);
    bus.rd_addr_b = ADDR_W'(b);
  endtask

  // Monitor: outputs are combinational, so they are valid at every falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c = sb_q.pop_front();
      case (c.sig)
        S_RDA:   act = bus.rd_data_a;
        S_RDB:   act = bus.rd_data_b;
        S_BSA:   act = {31'd0, bus.busy_a};
        S_BSB:   act = {31'd0, bus.busy_b};
        default: act = {31'd0, bus.clr_busy};
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_in();
    set_rd(0, 0);

    // Reset held: outputs zero even with a write presented for bypass.
    step();
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'h1234_5678;
    set_rd(5, 5);
    expect_val("rst_rda", S_RDA, 32'h0);
    expect_val("rst_clr", S_CLR, 32'h0);
    step();
    idle_in();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      set_rd(i, DEPTH - 1 - i);
      expect_val("init_rda", S_RDA, 32'h0);
      expect_val("init_rdb", S_RDB, 32'h0);
      expect_val("init_bsa", S_BSA, 32'h0);
      expect_val("init_bsb", S_BSB, 32'h0);
      expect_val("init_clr", S_CLR, 32'h0);
      step();
    end

    // Same-cycle bypass then stored value.
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hDEAD_BEEF;
    set_rd(5, 6);
    expect_val("byp_wr0", S_RDA, 32'hDEAD_BEEF);
    expect_val("byp_other", S_RDB, 32'h0);
    step();
    idle_in();
    expect_val("stored_r5", S_RDA, 32'hDEAD_BEEF);
    step();

    // Both ports to one address: load port wins.
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'h11;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'h22;
    set_rd(7, 5);
    expect_val("prio_byp", S_RDA, 32'h22);
    expect_val("r5_keep", S_RDB, 32'hDEAD_BEEF);
    step();
    idle_in();
    expect_val("prio_stored", S_RDA, 32'h22);
    step();

    // Zero register ignores writes and pending set.
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'hFFFF;
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd0;
    set_rd(0, 0);
    expect_val("zero_byp", S_RDA, 32'h0);
    step();
    idle_in();
    expect_val("zero_stored", S_RDA, 32'h0);
    expect_val("zero_busy", S_BSB, 32'h0);
    step();

    // Scoreboard set / clear / precedence.
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd9;
    set_rd(9, 9);
    expect_val("sb_before", S_BSA, 32'h0);
    step();
    idle_in();
    expect_val("sb_set_a", S_BSA, 32'h1);
    expect_val("sb_set_b", S_BSB, 32'h1);
    step();
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'h55;
    expect_val("sb_ret_busy", S_BSA, 32'h0);
    expect_val("sb_ret_data", S_RDA, 32'h55);
    step();
    idle_in();
    expect_val("sb_clr_busy", S_BSA, 32'h0);
    expect_val("sb_clr_data", S_RDA, 32'h55);
    step();
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd9;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'h66;
    expect_val("sb_both_busy", S_BSA, 32'h0);
    expect_val("sb_both_data", S_RDA, 32'h66);
    step();
    idle_in();
    expect_val("sb_setwins", S_BSA, 32'h1);
    step();
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'h77;
    expect_val("sb_wr0_busy", S_BSA, 32'h1);
    expect_val("sb_wr0_data", S_RDA, 32'h77);
    step();
    idle_in();
    expect_val("sb_wr0_keep", S_BSB, 32'h1);
    step();

    // Fill r1..r31; leave r9 pending and mark r12 pending too.
    for (int i = 1; i < DEPTH; i++) begin
      bus.wr0_en = 1'b1; bus.wr0_addr = ADDR_W'(i); bus.wr0_data = fill(i);
      step();
    end
    idle_in();
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd12;
    set_rd(17, 31);
    expect_val("fill_r17", S_RDA, fill(17));
    expect_val("fill_r31", S_RDB, fill(31));
    step();
    idle_in();
    set_rd(12, 9);
    expect_val("pre_bsa12", S_BSA, 32'h1);
    expect_val("pre_bsb9", S_BSB, 32'h1);

    // Clear request with a same-cycle write and pending set.
    bus.clr_req = 1'b1;
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd2; bus.wr0_data = 32'hBBBB;
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd4;
    expect_val("clr_req_clr", S_CLR, 32'h0);
    step();
    idle_in();
    for (int k = 0; k < DEPTH; k++) begin
      set_rd(k, (k == 0) ? 0 : k - 1);
      if (k == 5 || k == 6) bus.rd_addr_b = 5'd3;
      if (k == 5) begin
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h3333;
        bus.clr_req = 1'b1;
      end else begin
        bus.wr0_en = 1'b0;
        bus.clr_req = 1'b0;
      end
      expect_val("sweep_busy", S_CLR, 32'h1);
      expect_val("sweep_bsa", S_BSA, 32'h0);
      if (k == 0)      expect_val("sweep_cur", S_RDA, 32'h0);
      else if (k == 2) expect_val("sweep_cur", S_RDA, 32'hBBBB);
      else             expect_val("sweep_cur", S_RDA, fill(k));
      expect_val("sweep_done", S_RDB, 32'h0);
      step();
    end
    idle_in();
    expect_val("sweep_end_clr", S_CLR, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(i, i);
      expect_val("post_rda", S_RDA, 32'h0);
      expect_val("post_bsa", S_BSA, 32'h0);
      step();
    end

    // Reset in idle clears a pending bit.
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd9;
    step();
    idle_in();
    set_rd(9, 9);
    expect_val("pend_before_rst", S_BSA, 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_val("pend_after_rst", S_BSA, 32'h0);
    step();

    // Refill, start a sweep, reset mid-sweep at cycle 10.
    for (int i = 1; i < DEPTH; i++) begin
      bus.wr1_en = 1'b1; bus.wr1_addr = ADDR_W'(i); bus.wr1_data = fill(i);
      step();
    end
    idle_in();
    bus.clr_req = 1'b1;
    step();
    idle_in();
    for (int k = 0; k < 10; k++) begin
      expect_val("sweep2_busy", S_CLR, 32'h1);
      step();
    end
    rst = 1'b1;
    set_rd(20, 25);
    expect_val("midrst_clr", S_CLR, 32'h0);
    expect_val("midrst_rda", S_RDA, 32'h0);
    step();
    rst = 1'b0;
    expect_val("afterrst_clr", S_CLR, 32'h0);
    expect_val("afterrst_r20", S_RDA, 32'h0);
    expect_val("afterrst_r25", S_RDB, 32'h0);
    bus.clr_req = 1'b1;
    step();
    idle_in();
    for (int k = 0; k < DEPTH; k++) begin
      expect_val("sweep3_busy", S_CLR, 32'h1);
      step();
    end
    expect_val("sweep3_end", S_CLR, 32'h0);
    step();

    for (int n = 0; n < 10 && sb_q.size() > 0; n++) @(negedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
